mem_bank: RTL and testbench

MEM_BANK -- requirements
Module: mem_bank

---
 rtl/mem_bank.sv | 122 ++++++++++++
 tb/tb_mem_bank.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bank.sv
// Register-file memory bank with a rising-edge request strobe, fixed access latency,
// byte-enabled writes, registered read data and an out-of-range error flag.
module mem_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                sys_ctr,
    input  logic                sys_io,
    input  logic [ADDR_W-1:0]   sys_data_addr,
    input  logic [DATA_W-1:0]   sys_data_sv,
    input  logic [DATA_W/8-1:0] sys_be,
    output logic [DATA_W-1:0]   sys_data_rd,
    output logic                sys_done,
    output logic                sys_err
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {StIdle, StWork} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ctr_q;
    logic                io_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [BeW-1:0]      be_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_q;
    logic                err_q;

    logic                req;
    logic                accept;
    logic                complete;
    logic                in_range;
    logic [IdxW-1:0]     idx;

    assign req      = sys_ctr & ~ctr_q;
    assign in_range = 32'(addr_q) < DEPTH;
    assign idx      = addr_q[IdxW-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = StWork;
                    cnt_d   = '0;
                end
            end
            StWork: begin
                if (cnt_q == 4'(WAIT_CYC - 1)) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ctr_q resets high so a strobe held through reset is not seen as an edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ctr_q   <= 1'b1;
            io_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctr_q   <= sys_ctr;
            if (accept) begin
                io_q   <= sys_io;
                addr_q <= sys_data_addr;
                data_q <= sys_data_sv;
                be_q   <= sys_be;
            end
            if (complete) begin
                err_q <= ~in_range;
                if (io_q) begin
                    rd_q <= in_range ? mem_q[idx] : '0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                mem_q[w] <= '0;
            end
        end else if (complete && !io_q && in_range) begin
            for (int b = 0; b < int'(BeW); b++) begin
                if (be_q[b]) begin
                    mem_q[idx][8*b +: 8] <= data_q[8*b +: 8];
                end
            end
        end
    end

    assign sys_data_rd = rd_q;
    assign sys_done    = (state_q == StIdle);
    assign sys_err     = err_q;

endmodule

// File: tb/tb_mem_bank.sv
// Bench for mem_bank: two instances (WAIT_CYC=1 and WAIT_CYC=4, DEPTH=20) checked against
// an array-based model of the memory contents, read register and error flag.
module tb_mem_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctr1 = 1'b0;
    logic        ctr4 = 1'b0;
    logic        io_r = 1'b0;
    logic [4:0]  addr_r = '0;
    logic [31:0] data_r = '0;
    logic [3:0]  be_r = '0;
    logic [31:0] rd1, rd4;
    logic        done1, done4, err1, err4;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl [2][20];
    logic [31:0] exp_rd [2];
    logic        exp_err [2];
    int          lat [2];

    always #5 clk = ~clk;

    mem_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .WAIT_CYC(1)) u_dut1 (
        .sys_clk(clk), .sys_rst(rst), .sys_ctr(ctr1), .sys_io(io_r),
        .sys_data_addr(addr_r), .sys_data_sv(data_r), .sys_be(be_r),
        .sys_data_rd(rd1), .sys_done(done1), .sys_err(err1)
    );

    mem_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .WAIT_CYC(4)) u_dut4 (
        .sys_clk(clk), .sys_rst(rst), .sys_ctr(ctr4), .sys_io(io_r),
        .sys_data_addr(addr_r), .sys_data_sv(data_r), .sys_be(be_r),
        .sys_data_rd(rd4), .sys_done(done4), .sys_err(err4)
    );

    function automatic logic [31:0] rd_of(input int s);
        return (s == 0) ? rd1 : rd4;
    endfunction

    function automatic logic done_of(input int s);
        return (s == 0) ? done1 : done4;
    endfunction

    function automatic logic err_of(input int s);
        return (s == 0) ? err1 : err4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 20; w++) mdl[s][w] = '0;
            exp_rd[s]  = '0;
            exp_err[s] = 1'b0;
        end
    endtask

    task automatic model_access(input int s, input logic io, input int addr,
                                input logic [31:0] d, input logic [3:0] be);
        if (addr < 20) begin
            if (io) exp_rd[s] = mdl[s][addr];
            else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[s][addr][8*b +: 8] = d[8*b +: 8];
            end
            exp_err[s] = 1'b0;
        end else begin
            if (io) exp_rd[s] = '0;
            exp_err[s] = 1'b1;
        end
    endtask

    task automatic check_outputs(input int s, input string tag);
        check({tag, "_rd"}, rd_of(s), exp_rd[s]);
        check({tag, "_err"}, 32'(err_of(s)), 32'(exp_err[s]));
    endtask

    // One strobed access; inputs are scrambled right after acceptance.
    task automatic access(input int s, input logic io, input int addr, input logic [31:0] d,
                          input logic [3:0] be, input string tag);
        int low;
        @(negedge clk);
        io_r = io; addr_r = 5'(addr); data_r = d; be_r = be;
        if (s == 0) ctr1 = 1'b1; else ctr4 = 1'b1;
        @(negedge clk);
        ctr1 = 1'b0; ctr4 = 1'b0;
        io_r = ~io; addr_r = 5'($urandom); data_r = $urandom; be_r = 4'($urandom);
        low = 0;
        while (done_of(s) == 1'b0 && low < 40) begin
            low++;
            @(negedge clk);
        end
        model_access(s, io, addr, d, be);
        check({tag, "_busy"}, 32'(low), 32'(lat[s]));
        check_outputs(s, tag);
    endtask

    initial begin
        int low;
        logic [31:0] d;
        lat[0] = 1; lat[1] = 4;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_done1", 32'(done1), 32'd1);
        check("rst_done4", 32'(done4), 32'd1);
        check_outputs(0, "rst1");
        check_outputs(1, "rst4");

        // Basic write/read, then partial byte-enable write
        access(0, 1'b0, 3, 32'hDEADBEEF, 4'hF, "w3");
        access(0, 1'b1, 3, 32'h0, 4'h0, "r3");
        check("r3_const", rd1, 32'hDEADBEEF);
        access(0, 1'b0, 3, 32'h11223344, 4'h5, "w3be");
        access(0, 1'b1, 3, 32'h0, 4'h3, "r3be");
        check("r3be_const", rd1, 32'hDE22BE44);

        // Out-of-range write and read, then an in-range read clears the error
        access(0, 1'b0, 25, 32'hFFFFFFFF, 4'hF, "w25");
        access(0, 1'b1, 25, 32'h0, 4'hF, "r25");
        check("r25_err", 32'(err1), 32'd1);
        check("r25_rd", rd1, 32'h0);
        access(0, 1'b1, 3, 32'h0, 4'h0, "r3again");
        check("r3again_err", 32'(err1), 32'd0);

        // Randomized traffic on both latencies, including out-of-range addresses
        for (int i = 0; i < 60; i++) begin
            int s;
            s = (i % 4 == 3) ? 1 : 0;
            access(s, 1'($urandom), int'($urandom_range(0, 31)), $urandom, 4'($urandom),
                   $sformatf("rnd%0d", i));
        end

        // Second strobe during WORK is ignored and not queued
        @(negedge clk);
        io_r = 1'b1; addr_r = 5'd3; ctr4 = 1'b1;
        low = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4 == 1'b0) low++;
            ctr4 = (k == 1);
            if (k == 1) begin
                io_r = 1'b0; addr_r = 5'd3; data_r = 32'hA5A5A5A5; be_r = 4'hF;
            end
        end
        model_access(1, 1'b1, 3, 32'h0, 4'h0);
        check("ign_busy", 32'(low), 32'd4);
        check_outputs(1, "ign");
        access(1, 1'b1, 3, 32'h0, 4'h0, "ign_r3");

        // Reset during WORK aborts the write
        d = $urandom | 32'h1;
        @(negedge clk);
        io_r = 1'b0; addr_r = 5'd7; data_r = d; be_r = 4'hF; ctr4 = 1'b1;
        @(negedge clk);
        ctr4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        check("abort_done", 32'(done4), 32'd1);
        check_outputs(1, "abort");
        access(1, 1'b1, 7, 32'h0, 4'h0, "abort_r7");
        check("abort_r7_const", rd4, 32'h0);

        // Strobe held high through reset release must not start an access
        access(0, 1'b0, 5, 32'h12345678, 4'hF, "pre_w5");
        @(negedge clk);
        ctr1 = 1'b1; ctr4 = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hold_done1_%0d", k), 32'(done1), 32'd1);
            check($sformatf("hold_done4_%0d", k), 32'(done4), 32'd1);
        end
        ctr1 = 1'b0; ctr4 = 1'b0;
        access(0, 1'b1, 5, 32'h0, 4'h0, "hold_r5");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold_idle_%0d", k), 32'(done1), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
